// File: rtl/m72_pkg.sv
// Shared types for the M72 SDRAM CPU-side path: arbiter states, the buffered
// command word, and the data returned when an access is aborted.
package m72_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_WAIT = 2'd1,
      ARB_DONE = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic [24:1] addr;
      logic [15:0] din;
      logic [1:0]  wr_sel;
   } sdr_cmd_t;

   localparam logic [15:0] SDR_TIMEOUT_DATA = 16'hFFFF;

endpackage

// File: rtl/sdr_req_slot.sv
// One-deep request buffer for a single requester: holds the pending flag and
// the captured command until the arbiter grants it.
module sdr_req_slot
   import m72_pkg::*;
(
   input  logic     CLK_32M,
   input  logic     reset_n,
   input  logic     req,
   input  sdr_cmd_t cmd_in,
   input  logic     in_flight,
   input  logic     grant,
   output logic     pending,
   output sdr_cmd_t cmd,
   output logic     overrun
);

   logic is_free;

   assign is_free = !pending && !in_flight;
   assign overrun = req && !is_free;

   // A grant can only hit a pending slot, so capture and clear never coincide.
   always_ff @(posedge CLK_32M or negedge reset_n) begin
      if (!reset_n) begin
         pending <= 1'b0;
         cmd     <= '0;
      end else if (req && is_free) begin
         pending <= 1'b1;
         cmd     <= cmd_in;
      end else if (grant) begin
         pending <= 1'b0;
      end
   end

endmodule

// File: rtl/sdr_cpu_arbiter.sv
// Round-robin arbiter sharing the CPU-side SDRAM port between the V30 path
// (port 0) and the sound/MCU ROM path (port 1), with a watchdog on sdr_rdy.
module sdr_cpu_arbiter
   import m72_pkg::*;
#(
   parameter int TIMEOUT = 1023
) (
   input  logic        CLK_32M,
   input  logic        reset_n,
   input  logic        hold,
   input  logic        p0_req,
   input  logic        p1_req,
   input  logic [24:1] p0_addr,
   input  logic [24:1] p1_addr,
   input  logic [15:0] p0_din,
   input  logic [15:0] p1_din,
   input  logic [1:0]  p0_wr_sel,
   input  logic [1:0]  p1_wr_sel,
   output logic [15:0] p0_dout,
   output logic [15:0] p1_dout,
   output logic        p0_ack,
   output logic        p1_ack,
   output logic [24:1] sdr_addr,
   output logic [15:0] sdr_din,
   output logic [1:0]  sdr_wr_sel,
   output logic        sdr_req,
   input  logic        sdr_rdy,
   input  logic [15:0] sdr_dout,
   output logic        busy,
   output logic        err_timeout,
   output logic        err_overrun
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_LIMIT = TW'(TIMEOUT);
   localparam logic [TW-1:0] TIMER_MAX   = {TW{1'b1}};

   arb_state_t  state, next_state;
   logic        last_grant;
   logic [TW-1:0] timer;

   logic        p0_pending, p1_pending;
   logic        p0_overrun, p1_overrun;
   sdr_cmd_t    p0_cmd, p1_cmd, win_cmd;
   logic        issue, sel, rdy_done, to_done, finish;
   logic [15:0] done_data;

   sdr_req_slot u_slot0 (
      .CLK_32M   (CLK_32M),
      .reset_n   (reset_n),
      .req       (p0_req),
      .cmd_in    ('{addr: p0_addr, din: p0_din, wr_sel: p0_wr_sel}),
      .in_flight (state == ARB_WAIT && last_grant == 1'b0),
      .grant     (issue && sel == 1'b0),
      .pending   (p0_pending),
      .cmd       (p0_cmd),
      .overrun   (p0_overrun)
   );

   sdr_req_slot u_slot1 (
      .CLK_32M   (CLK_32M),
      .reset_n   (reset_n),
      .req       (p1_req),
      .cmd_in    ('{addr: p1_addr, din: p1_din, wr_sel: p1_wr_sel}),
      .in_flight (state == ARB_WAIT && last_grant == 1'b1),
      .grant     (issue && sel == 1'b1),
      .pending   (p1_pending),
      .cmd       (p1_cmd),
      .overrun   (p1_overrun)
   );

   always_ff @(posedge CLK_32M or negedge reset_n) begin
      if (!reset_n) state <= ARB_IDLE;
      else          state <= next_state;
   end

   // On a tie the port that did not win last time goes next.
   always_comb begin
      next_state = state;
      issue      = 1'b0;
      sel        = last_grant;
      rdy_done   = 1'b0;
      to_done    = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (!hold && (p0_pending || p1_pending)) begin
               issue      = 1'b1;
               sel        = (p0_pending && p1_pending) ? ~last_grant : p1_pending;
               next_state = ARB_WAIT;
            end
         end
         ARB_WAIT: begin
            if (sdr_rdy) begin
               rdy_done   = 1'b1;
               next_state = ARB_DONE;
            end else if (timer >= TIMER_LIMIT) begin
               to_done    = 1'b1;
               next_state = ARB_DONE;
            end
         end
         ARB_DONE: next_state = ARB_IDLE;
         default:  next_state = ARB_IDLE;
      endcase
   end

   assign win_cmd   = sel ? p1_cmd : p0_cmd;
   assign finish    = rdy_done || to_done;
   assign done_data = rdy_done ? sdr_dout : SDR_TIMEOUT_DATA;
   assign busy      = (state != ARB_IDLE) || p0_pending || p1_pending;

   // SDRAM command fields only move in the issue cycle; acks are registered so
   // they line up with the DONE state.
   always_ff @(posedge CLK_32M or negedge reset_n) begin
      if (!reset_n) begin
         last_grant  <= 1'b1;
         timer       <= '0;
         sdr_req     <= 1'b0;
         sdr_addr    <= '0;
         sdr_din     <= '0;
         sdr_wr_sel  <= '0;
         p0_dout     <= '0;
         p1_dout     <= '0;
         p0_ack      <= 1'b0;
         p1_ack      <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         sdr_req <= 1'b0;
         p0_ack  <= 1'b0;
         p1_ack  <= 1'b0;
         if (issue) begin
            sdr_req    <= 1'b1;
            sdr_addr   <= win_cmd.addr;
            sdr_din    <= win_cmd.din;
            sdr_wr_sel <= win_cmd.wr_sel;
            last_grant <= sel;
            timer      <= '0;
         end else if (state == ARB_WAIT && !finish && timer != TIMER_MAX) begin
            timer <= timer + 1'b1;
         end
         if (finish) begin
            if (last_grant) begin
               p1_ack  <= 1'b1;
               p1_dout <= done_data;
            end else begin
               p0_ack  <= 1'b1;
               p0_dout <= done_data;
            end
         end
         if (to_done)
            err_timeout <= 1'b1;
         if (p0_overrun || p1_overrun)
            err_overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sdr_cpu_arbiter.sv
// Directed bench for sdr_cpu_arbiter with a short watchdog (TIMEOUT = 8).
module tb_sdr_cpu_arbiter;

   logic        CLK_32M = 1'b0;
   logic        reset_n = 1'b0;
   logic        hold = 1'b0;
   logic        p0_req = 1'b0, p1_req = 1'b0;
   logic [24:1] p0_addr = '0, p1_addr = '0;
   logic [15:0] p0_din = '0, p1_din = '0;
   logic [1:0]  p0_wr_sel = '0, p1_wr_sel = '0;
   logic [15:0] p0_dout, p1_dout;
   logic        p0_ack, p1_ack;
   logic [24:1] sdr_addr;
   logic [15:0] sdr_din;
   logic [1:0]  sdr_wr_sel;
   logic        sdr_req;
   logic        sdr_rdy = 1'b0;
   logic [15:0] sdr_dout = '0;
   logic        busy, err_timeout, err_overrun;

   int tests_run = 0;
   int tests_failed = 0;

   sdr_cpu_arbiter #(.TIMEOUT(8)) dut (
      .CLK_32M     (CLK_32M),
      .reset_n     (reset_n),
      .hold        (hold),
      .p0_req      (p0_req),
      .p1_req      (p1_req),
      .p0_addr     (p0_addr),
      .p1_addr     (p1_addr),
      .p0_din      (p0_din),
      .p1_din      (p1_din),
      .p0_wr_sel   (p0_wr_sel),
      .p1_wr_sel   (p1_wr_sel),
      .p0_dout     (p0_dout),
      .p1_dout     (p1_dout),
      .p0_ack      (p0_ack),
      .p1_ack      (p1_ack),
      .sdr_addr    (sdr_addr),
      .sdr_din     (sdr_din),
      .sdr_wr_sel  (sdr_wr_sel),
      .sdr_req     (sdr_req),
      .sdr_rdy     (sdr_rdy),
      .sdr_dout    (sdr_dout),
      .busy        (busy),
      .err_timeout (err_timeout),
      .err_overrun (err_overrun)
   );

   always #5 CLK_32M = ~CLK_32M;

   task automatic tick();
      @(posedge CLK_32M);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check_output({tag, "_sdr_req"}, 32'(sdr_req), 32'h0);
      check_output({tag, "_sdr_addr"}, 32'(sdr_addr), 32'h0);
      check_output({tag, "_sdr_din"}, 32'(sdr_din), 32'h0);
      check_output({tag, "_sdr_wr_sel"}, 32'(sdr_wr_sel), 32'h0);
      check_output({tag, "_douts"}, {p0_dout, p1_dout}, 32'h0);
      check_output({tag, "_acks"}, 32'({p0_ack, p1_ack}), 32'h0);
      check_output({tag, "_busy"}, 32'(busy), 32'h0);
      check_output({tag, "_errs"}, 32'({err_timeout, err_overrun}), 32'h0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic pulse_rdy(input logic [15:0] data);
      sdr_rdy  = 1'b1;
      sdr_dout = data;
      tick();
      sdr_rdy  = 1'b0;
      sdr_dout = '0;
   endtask

   initial begin
      #1;
      check_idle_outputs("reset");
      do_reset();

      // Single read: req at N, sdr_req at N+2, rdy at N+4, ack at N+5
      p0_req = 1'b1; p0_addr = 24'h000100; p0_wr_sel = 2'b00;
      tick();
      p0_req = 1'b0;
      check_output("rd_busy_n1", 32'(busy), 32'h1);
      check_output("rd_no_req_n1", 32'(sdr_req), 32'h0);
      tick();
      check_output("rd_sdr_req_n2", 32'(sdr_req), 32'h1);
      check_output("rd_sdr_addr", 32'(sdr_addr), 32'h000100);
      check_output("rd_wr_sel", 32'(sdr_wr_sel), 32'h0);
      tick();
      check_output("rd_req_pulse_n3", 32'(sdr_req), 32'h0);
      tick();
      pulse_rdy(16'hBEEF);
      check_output("rd_p0_ack_n5", 32'(p0_ack), 32'h1);
      check_output("rd_p0_dout", 32'(p0_dout), 32'hBEEF);
      check_output("rd_p1_ack", 32'(p1_ack), 32'h0);
      tick();
      check_output("rd_ack_pulse", 32'(p0_ack), 32'h0);
      check_output("rd_dout_held", 32'(p0_dout), 32'hBEEF);
      check_output("rd_busy_end", 32'(busy), 32'h0);

      // Tie after reset: port 0 then port 1, twice
      do_reset();
      for (int pair = 0; pair < 2; pair++) begin
         p0_req = 1'b1; p0_addr = 24'h000A00 + 24'(pair);
         p1_req = 1'b1; p1_addr = 24'h000B00 + 24'(pair);
         tick();
         p0_req = 1'b0; p1_req = 1'b0;
         tick();
         check_output($sformatf("tie%0d_first_req", pair), 32'(sdr_req), 32'h1);
         check_output($sformatf("tie%0d_first_addr", pair), 32'(sdr_addr), 32'h000A00 + pair);
         tick();
         pulse_rdy(16'h1100 + 16'(pair));
         check_output($sformatf("tie%0d_p0_ack", pair), 32'({p0_ack, p1_ack}), 32'h2);
         check_output($sformatf("tie%0d_p0_dout", pair), 32'(p0_dout), 32'h1100 + pair);
         tick();
         check_output($sformatf("tie%0d_gap", pair), 32'(sdr_req), 32'h0);
         tick();
         check_output($sformatf("tie%0d_second_req", pair), 32'(sdr_req), 32'h1);
         check_output($sformatf("tie%0d_second_addr", pair), 32'(sdr_addr), 32'h000B00 + pair);
         tick();
         pulse_rdy(16'h2200 + 16'(pair));
         check_output($sformatf("tie%0d_p1_ack", pair), 32'({p0_ack, p1_ack}), 32'h1);
         check_output($sformatf("tie%0d_p1_dout", pair), 32'(p1_dout), 32'h2200 + pair);
         tick();
      end

      // Write on port 1: fields held from sdr_req until ack
      p1_req = 1'b1; p1_addr = 24'h123456; p1_din = 16'h1234; p1_wr_sel = 2'b10;
      tick();
      p1_req = 1'b0; p1_din = 16'h0000; p1_wr_sel = 2'b00;
      tick();
      check_output("wr_sdr_req", 32'(sdr_req), 32'h1);
      for (int k = 0; k < 3; k++) begin
         check_output($sformatf("wr_fields_%0d", k), {14'h0, sdr_wr_sel, sdr_din}, 32'h21234);
         tick();
      end
      pulse_rdy(16'h0000);
      check_output("wr_p1_ack", 32'(p1_ack), 32'h1);
      check_output("wr_fields_at_ack", {14'h0, sdr_wr_sel, sdr_din}, 32'h21234);
      check_output("wr_addr_at_ack", 32'(sdr_addr), 32'h123456);
      tick();

      // Timeout: no rdy, ack exactly 9 cycles after sdr_req
      p0_req = 1'b1; p0_addr = 24'h0000C0;
      tick();
      p0_req = 1'b0;
      tick();
      check_output("to_sdr_req", 32'(sdr_req), 32'h1);
      for (int k = 1; k <= 8; k++) begin
         tick();
         check_output($sformatf("to_no_ack_%0d", k), 32'(p0_ack), 32'h0);
      end
      tick();
      check_output("to_p0_ack", 32'(p0_ack), 32'h1);
      check_output("to_p0_dout", 32'(p0_dout), 32'hFFFF);
      check_output("to_err", 32'(err_timeout), 32'h1);
      tick();
      p1_req = 1'b1; p1_addr = 24'h0000D0;
      tick();
      p1_req = 1'b0;
      tick();
      check_output("to_next_req", 32'(sdr_req), 32'h1);
      tick();
      pulse_rdy(16'h5A5A);
      check_output("to_next_ack", 32'({p0_ack, p1_ack}), 32'h1);
      check_output("to_next_dout", 32'(p1_dout), 32'h5A5A);
      tick();

      // Overrun: second p0_req while port 0 is in WAIT
      check_output("ov_clear", 32'(err_overrun), 32'h0);
      p0_req = 1'b1; p0_addr = 24'h000E00;
      tick();
      p0_req = 1'b0;
      tick();
      check_output("ov_sdr_req", 32'(sdr_req), 32'h1);
      tick();
      p0_req = 1'b1; p0_addr = 24'h000F00;
      tick();
      p0_req = 1'b0;
      check_output("ov_err", 32'(err_overrun), 32'h1);
      pulse_rdy(16'h7777);
      check_output("ov_ack", 32'(p0_ack), 32'h1);
      for (int k = 0; k < 3; k++) begin
         tick();
         check_output($sformatf("ov_no_extra_req_%0d", k), 32'(sdr_req), 32'h0);
      end
      check_output("ov_addr_kept", 32'(sdr_addr), 32'h000E00);

      // Hold blocks issue; release gives sdr_req on the following cycle
      hold = 1'b1;
      p1_req = 1'b1; p1_addr = 24'h000777;
      tick();
      p1_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check_output($sformatf("hold_no_req_%0d", k), 32'(sdr_req), 32'h0);
         tick();
      end
      check_output("hold_busy", 32'(busy), 32'h1);
      hold = 1'b0;
      tick();
      check_output("hold_release_req", 32'(sdr_req), 32'h1);
      check_output("hold_release_addr", 32'(sdr_addr), 32'h000777);
      tick();
      pulse_rdy(16'h0BAD);
      check_output("hold_ack", 32'(p1_ack), 32'h1);
      tick();

      // Reset in the middle of WAIT, then a late rdy
      p0_req = 1'b1; p0_addr = 24'h000333;
      tick();
      p0_req = 1'b0;
      tick();
      check_output("rst_mid_req", 32'(sdr_req), 32'h1);
      tick();
      reset_n = 1'b0;
      #1;
      check_idle_outputs("rst_mid");
      tick();
      reset_n = 1'b1;
      pulse_rdy(16'hDEAD);
      check_output("rst_late_no_ack", 32'({p0_ack, p1_ack}), 32'h0);
      tick();
      check_idle_outputs("rst_late");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
